// File: rtl/apb_cmd_master_if.sv
// Bundle of the command stream, the response stream and the APB3 bus
// signals used by apb_cmd_master.
// The master modport is the requester's view; the slave modport is the view
// of the command source, response sink and APB fabric around it.
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response stream
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB3 bus
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into IDLE/SETUP/ACCESS
// transfers and returns one single-cycle response per command.
// Optional feature macro: APB_TIMEOUT_EN. When defined, an ACCESS phase that
// sees PREADY low for TIMEOUT_CYCLES cycles is aborted with an error and
// timeout response. When undefined, ACCESS waits indefinitely and
// rsp_timeout is constant 0.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_cmd_master_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rsp_timeout_q, rsp_timeout_d;
`endif

    // Commands are only taken while the bus is idle.
    assign bus.cmd_ready   = (state_q == S_IDLE);

    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                penable_d  = 1'b1;
                state_d    = S_ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            S_ACCESS: begin
                // A completing PREADY takes priority over a coincident timeout.
                if (bus.PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_cnt_q == CNT_LAST) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= S_IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed commands against a wait-state
// programmable APB slave; expected responses go through a scoreboard queue
// and are checked by an independent response monitor.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            lat;
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESETn;

    apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    exp_t sb_q[$];
    int   acc_q[$];

    int            sl_ws    = 0;
    logic [DW-1:0] sl_rdata = '0;
    logic          sl_err   = 1'b0;
    int            acc_cnt  = 0;

    bit gap_on  = 1'b0;
    int gap_run = 0;
    int max_gap = 0;
    bit gap_seen = 1'b0;

    int last_acc = 0;

    assign bus.PRDATA  = sl_rdata;
    assign bus.PSLVERR = sl_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave: PREADY rises after sl_ws ACCESS cycles; outside ACCESS it is
    // driven high when sl_ws==0 so the requester must ignore it there.
    always @(negedge PCLK) begin
        if (bus.PSEL && bus.PENABLE) begin
            bus.PREADY <= (acc_cnt >= sl_ws);
            acc_cnt    <= acc_cnt + 1;
        end else begin
            bus.PREADY <= (sl_ws == 0);
            acc_cnt    <= 0;
        end
    end

    // Longest run of PSEL low between transfers while gap tracking is on.
    always @(negedge PCLK) begin
        if (!gap_on) begin
            gap_run  <= 0;
            max_gap  <= 0;
            gap_seen <= 1'b0;
        end else if (bus.PSEL) begin
            if (gap_seen && gap_run > max_gap) max_gap <= gap_run;
            gap_run  <= 0;
            gap_seen <= 1'b1;
        end else begin
            gap_run <= gap_run + 1;
        end
    end

    // Response monitor: pops the scoreboard on every rsp_valid.
    always @(negedge PCLK) begin
        if (PRESETn && bus.rsp_valid) begin
            if (sb_q.size() == 0 || acc_q.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                int   a;
                e = sb_q.pop_front();
                a = acc_q.pop_front();
                check("rsp_rdata",   64'(bus.rsp_rdata),   64'(e.rdata));
                check("rsp_err",     64'(bus.rsp_err),     64'(e.err));
                check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
                check("rsp_latency", 64'(cyc + 1 - a),     64'(e.lat));
            end
        end
    end

    task automatic expect_rsp(input logic [DW-1:0] rdata, input logic err,
                              input logic tmo, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.tmo   = tmo;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    // Offer a command and wait (bounded) for its accepting edge.
    task automatic send(input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input bit hold, input bit track);
        int n;
        n = 0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(n), 64'd0);
        @(posedge PCLK);
        #1;
        if (track) acc_q.push_back(cyc);
        last_acc = cyc;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < bound) begin
            @(negedge PCLK);
            n++;
        end
        check("sb_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int ps, pe, unstable, prev;

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        repeat (3) @(negedge PCLK);

        // Reset state
        check("rst_psel",      64'(bus.PSEL),      64'd0);
        check("rst_penable",   64'(bus.PENABLE),   64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_paddr",     64'(bus.PADDR),     64'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // 1: zero-wait write
        sl_ws = 0; sl_rdata = 32'h5555_AAAA; sl_err = 1'b0;
        expect_rsp(32'h0, 1'b0, 1'b0, 3);
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1);
        ps = 0; pe = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            if (i == 0) begin
                check("t1_paddr",  64'(bus.PADDR),  64'h10);
                check("t1_pwdata", 64'(bus.PWDATA), 64'hDEAD_BEEF);
                check("t1_pwrite", 64'(bus.PWRITE), 64'd1);
            end
            if (bus.PSEL) ps++;
            if (bus.PENABLE) pe++;
        end
        check("t1_psel_cycles",    64'(ps), 64'd2);
        check("t1_penable_cycles", 64'(pe), 64'd1);
        check("t1_idle_paddr",     64'(bus.PADDR), 64'h10);
        drain(20);

        // 2: read with 3 wait states
        sl_ws = 3; sl_rdata = 32'h1234_5678; sl_err = 1'b0;
        expect_rsp(32'h1234_5678, 1'b0, 1'b0, 6);
        send(1'b0, 32'h1000_0004, 32'h0BAD_0BAD, 1'b0, 1'b1);
        ps = 0; unstable = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge PCLK);
            if (bus.PSEL) begin
                ps++;
                if (bus.PADDR !== 32'h1000_0004 || bus.PWRITE !== 1'b0) unstable++;
            end
        end
        check("t2_psel_cycles", 64'(ps), 64'd5);
        check("t2_unstable",    64'(unstable), 64'd0);
        drain(20);

        // 3: read completing with PSLVERR
        sl_ws = 0; sl_rdata = 32'hCAFE_0001; sl_err = 1'b1;
        expect_rsp(32'hCAFE_0001, 1'b1, 1'b0, 3);
        send(1'b0, 32'h2000_0000, 32'h0, 1'b0, 1'b1);
        drain(20);

        // 4: four back-to-back writes with cmd_valid held
        sl_ws = 0; sl_rdata = 32'h7777_7777; sl_err = 1'b0;
        gap_on = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_rsp(32'h0, 1'b0, 1'b0, 3);
            prev = last_acc;
            send(1'b1, 32'h3000_0000 + 32'(k * 4), 32'hA000_0000 + 32'(k), (k != 3), 1'b1);
            if (k > 0) check("t4_accept_spacing", 64'(last_acc - prev), 64'd3);
        end
        repeat (5) @(negedge PCLK);
        check("t4_max_psel_gap", 64'(max_gap), 64'd1);
        check("t4_last_pwdata",  64'(bus.PWDATA), 64'hA000_0003);
        gap_on = 1'b0;
        drain(20);

        // 5: reset during ACCESS
        sl_ws = 1000;
        send(1'b0, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (!(bus.PSEL && bus.PENABLE) && n < 10) begin
                @(negedge PCLK);
                n++;
            end
        end
        check("t5_in_access", 64'(bus.PENABLE), 64'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        check("t5_rst_psel",    64'(bus.PSEL),      64'd0);
        check("t5_rst_penable", 64'(bus.PENABLE),   64'd0);
        check("t5_cmd_ready",   64'(bus.cmd_ready), 64'd1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        sl_ws = 0; sl_rdata = 32'h0BEE_F00D; sl_err = 1'b0;
        expect_rsp(32'h0BEE_F00D, 1'b0, 1'b0, 3);
        send(1'b0, 32'h4000_0008, 32'h0, 1'b0, 1'b1);
        drain(20);

        // 6: PREADY held low
        sl_ws = 1000; sl_rdata = 32'h9999_9999; sl_err = 1'b0;
`ifdef APB_TIMEOUT_EN
        expect_rsp(32'h0, 1'b1, 1'b1, TO + 2);
        send(1'b0, 32'h5000_0000, 32'h0, 1'b0, 1'b1);
        drain(30);
        check("t6_psel_after_abort", 64'(bus.PSEL), 64'd0);
`else
        send(1'b0, 32'h5000_0000, 32'h0, 1'b0, 1'b0);
        repeat (100) @(negedge PCLK);
        check("t6_still_psel",    64'(bus.PSEL),      64'd1);
        check("t6_still_penable", 64'(bus.PENABLE),   64'd1);
        check("t6_not_ready",     64'(bus.cmd_ready), 64'd0);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
`endif
        sl_ws = 0;
        repeat (3) @(negedge PCLK);
        check("final_acc_q_empty", 64'(acc_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
